// File: rtl/ascon_lane_io_if.sv
// ----------------------------------------------------------------------------
// ascon_lane_io_if
//   Lane bus between the chip-level pin/bus logic and the Ascon front end.
//   Carries the W-bit write lane (valid/ready, field select, payload) and the
//   W-bit output lane (valid/ready, payload, tag marker, last marker).
//
//   master : the bus side. It drives the write lane and out_ready.
//   slave  : the front end. It drives in_ready and the output lane.
// ----------------------------------------------------------------------------
interface ascon_lane_io_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [W-1:0] in_lane;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_lane;
  logic         out_is_tag;
  logic         out_last;

  modport master (
    output in_valid, in_sel, in_lane, out_ready,
    input  in_ready, out_valid, out_lane, out_is_tag, out_last
  );

  modport slave (
    input  in_valid, in_sel, in_lane, out_ready,
    output in_ready, out_valid, out_lane, out_is_tag, out_last
  );
endinterface

// File: rtl/ascon_lane_io.sv
// ----------------------------------------------------------------------------
// ascon_lane_io
//   Serial front end for the Ascon AEAD core. Key, nonce, associated data and
//   input data are loaded field by field over a W-bit lane. A start request
//   launches the core once every field is complete. The core result (data,
//   then tag) is streamed back out MSB first with backpressure.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   bus            lane interface (slave side): in_valid/in_ready/in_sel/
//                  in_lane writes, out_valid/out_ready/out_lane/out_is_tag/
//                  out_last output beats
//   start, decrypt core start request and mode (mode sampled with start)
//   loaded[3:0]    per-field complete flags, bit index = in_sel
//                  (0 key, 1 nonce, 2 AD, 3 data)
//   busy           high while the core runs or the result is unloading
//   err            one-cycle pulse, the cycle after a dropped write to a full
//                  field or a start request with incomplete fields
//   core_*         field registers, start pulse and latched mode to the core
//   core_out_data, core_tag, core_ready   core result and done level
//
// The interface instance must be built with the same W as this module.
// ----------------------------------------------------------------------------
module ascon_lane_io #(
  parameter int K        = 128,
  parameter int L        = 40,
  parameter int Y        = 104,
  parameter int W        = 8,
  parameter bit KEEP_KEY = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  ascon_lane_io_if.slave bus,
  input  logic           start,
  input  logic           decrypt,
  output logic [3:0]     loaded,
  output logic           busy,
  output logic           err,
  output logic [K-1:0]   core_key,
  output logic [127:0]   core_nonce,
  output logic [L-1:0]   core_ad,
  output logic [Y-1:0]   core_data,
  output logic           core_start,
  output logic           core_decrypt,
  input  logic [Y-1:0]   core_out_data,
  input  logic [127:0]   core_tag,
  input  logic           core_ready
);

  // Beats per field and per unload.
  localparam int KB   = K / W;
  localparam int NB   = 128 / W;
  localparam int AB   = L / W;
  localparam int DB   = Y / W;
  localparam int TB   = 128 / W;
  localparam int OB   = DB + TB;
  localparam int OW   = Y + 128;
  localparam int MX1  = (KB > NB) ? KB : NB;
  localparam int MX2  = (AB > DB) ? AB : DB;
  localparam int MAXB = (MX1 > MX2) ? MX1 : MX2;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int OCW  = $clog2(OB + 1);

  localparam logic [CW-1:0]  K_LAST   = CW'(KB - 1);
  localparam logic [CW-1:0]  N_LAST   = CW'(NB - 1);
  localparam logic [CW-1:0]  A_LAST   = CW'(AB - 1);
  localparam logic [CW-1:0]  D_LAST   = CW'(DB - 1);
  localparam logic [OCW-1:0] OB_LAST  = OCW'(OB - 1);
  localparam logic [OCW-1:0] TAG_BEAT = OCW'(DB);

  if (!(W == 1 || W == 2 || W == 4 || W == 8) ||
      (K % W) != 0 || (L % W) != 0 || (Y % W) != 0) begin : g_param_check
    $error("ascon_lane_io: W must be 1, 2, 4 or 8 and divide K, L and Y");
  end

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RUN    = 2'd1,
    S_UNLOAD = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [K-1:0]   key_q;
  logic [127:0]   nonce_q;
  logic [L-1:0]   ad_q;
  logic [Y-1:0]   data_q;
  logic [CW-1:0]  key_cnt_q, nonce_cnt_q, ad_cnt_q, data_cnt_q;
  logic [3:0]     loaded_q;
  logic           err_q;
  logic           core_start_q;
  logic           core_decrypt_q;
  logic [OW-1:0]  out_sr_q;
  logic [OCW-1:0] obeat_q;

  logic [3:0]     wr_en;
  logic           wr_drop;
  logic           start_ok;
  logic           start_bad;
  logic           capture;
  logic           out_hs;
  logic           done;

  // ---------------------------------------------------------------------------
  // Control: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control: next state and per-cycle decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    wr_en     = 4'b0000;
    wr_drop   = 1'b0;
    start_ok  = 1'b0;
    start_bad = 1'b0;
    capture   = 1'b0;
    out_hs    = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_LOAD: begin
        // in_ready is high in LOAD, so in_valid alone is an accepted write.
        if (bus.in_valid) begin
          if (loaded_q[bus.in_sel]) begin
            wr_drop = 1'b1;
          end else begin
            wr_en[bus.in_sel] = 1'b1;
          end
        end
        // The start check uses the flags as they stood before this cycle's
        // write, so a final beat and start in the same cycle is refused.
        if (start) begin
          if (&loaded_q) begin
            start_ok = 1'b1;
            state_d  = S_RUN;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_RUN: begin
        // A done level left over from the previous operation must not be
        // taken while the start pulse is still on its way to the core.
        if (core_ready && !core_start_q) begin
          capture = 1'b1;
          state_d = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        out_hs = bus.out_ready;
        if (out_hs && (obeat_q == OB_LAST)) begin
          done    = 1'b1;
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Field registers, flags, pulses and output shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q          <= '0;
      nonce_q        <= '0;
      ad_q           <= '0;
      data_q         <= '0;
      key_cnt_q      <= '0;
      nonce_cnt_q    <= '0;
      ad_cnt_q       <= '0;
      data_cnt_q     <= '0;
      loaded_q       <= 4'b0000;
      err_q          <= 1'b0;
      core_start_q   <= 1'b0;
      core_decrypt_q <= 1'b0;
      out_sr_q       <= '0;
      obeat_q        <= '0;
    end else begin
      err_q        <= wr_drop || start_bad;
      core_start_q <= start_ok;
      if (start_ok) begin
        core_decrypt_q <= decrypt;
      end

      if (done) begin
        nonce_q          <= '0;
        ad_q             <= '0;
        data_q           <= '0;
        nonce_cnt_q      <= '0;
        ad_cnt_q         <= '0;
        data_cnt_q       <= '0;
        loaded_q[3:1]    <= 3'b000;
        if (!KEEP_KEY) begin
          key_q       <= '0;
          key_cnt_q   <= '0;
          loaded_q[0] <= 1'b0;
        end
      end else begin
        if (wr_en[0]) begin
          key_q     <= (key_q << W) | K'(bus.in_lane);
          key_cnt_q <= key_cnt_q + 1'b1;
          if (key_cnt_q == K_LAST) loaded_q[0] <= 1'b1;
        end
        if (wr_en[1]) begin
          nonce_q     <= (nonce_q << W) | 128'(bus.in_lane);
          nonce_cnt_q <= nonce_cnt_q + 1'b1;
          if (nonce_cnt_q == N_LAST) loaded_q[1] <= 1'b1;
        end
        if (wr_en[2]) begin
          ad_q     <= (ad_q << W) | L'(bus.in_lane);
          ad_cnt_q <= ad_cnt_q + 1'b1;
          if (ad_cnt_q == A_LAST) loaded_q[2] <= 1'b1;
        end
        if (wr_en[3]) begin
          data_q     <= (data_q << W) | Y'(bus.in_lane);
          data_cnt_q <= data_cnt_q + 1'b1;
          if (data_cnt_q == D_LAST) loaded_q[3] <= 1'b1;
        end
      end

      // Data sits above the tag so one left shift walks data MSB-first and
      // then the tag MSB-first.
      if (capture) begin
        out_sr_q <= {core_out_data, core_tag};
        obeat_q  <= '0;
      end else if (out_hs) begin
        out_sr_q <= out_sr_q << W;
        obeat_q  <= obeat_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready   = (state_q == S_LOAD);
  assign bus.out_valid  = (state_q == S_UNLOAD);
  assign bus.out_lane   = bus.out_valid ? out_sr_q[OW-1 -: W] : '0;
  assign bus.out_is_tag = bus.out_valid && (obeat_q >= TAG_BEAT);
  assign bus.out_last   = bus.out_valid && (obeat_q == OB_LAST);

  assign busy         = (state_q != S_LOAD);
  assign loaded       = loaded_q;
  assign err          = err_q;
  assign core_start   = core_start_q;
  assign core_decrypt = core_decrypt_q;
  assign core_key     = key_q;
  assign core_nonce   = nonce_q;
  assign core_ad      = ad_q;
  assign core_data    = data_q;

endmodule

// File: tb/tb_ascon_lane_io.sv
// ----------------------------------------------------------------------------
// tb_ascon_lane_io
//   Bench for ascon_lane_io at default parameters (K=128, L=40, Y=104, W=8,
//   KEEP_KEY=1). Stimulus issues lane writes and core results; a reference
//   model tracks each field as the concatenation of its accepted beats and
//   queues every expected output beat; a monitor pops and compares beats on
//   each output handshake.
// ----------------------------------------------------------------------------
module tb_ascon_lane_io;
  localparam int W = 8;
  localparam int K = 128;
  localparam int L = 40;
  localparam int Y = 104;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         decrypt = 1'b0;
  logic [3:0]   loaded;
  logic         busy;
  logic         err;
  logic [K-1:0] core_key;
  logic [127:0] core_nonce;
  logic [L-1:0] core_ad;
  logic [Y-1:0] core_data;
  logic         core_start;
  logic         core_decrypt;
  logic [Y-1:0] core_out_data = '0;
  logic [127:0] core_tag = '0;
  logic         core_ready = 1'b0;

  ascon_lane_io_if #(.W(W)) bus ();

  ascon_lane_io #(
    .K(K), .L(L), .Y(Y), .W(W), .KEEP_KEY(1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .start         (start),
    .decrypt       (decrypt),
    .loaded        (loaded),
    .busy          (busy),
    .err           (err),
    .core_key      (core_key),
    .core_nonce    (core_nonce),
    .core_ad       (core_ad),
    .core_data     (core_data),
    .core_start    (core_start),
    .core_decrypt  (core_decrypt),
    .core_out_data (core_out_data),
    .core_tag      (core_tag),
    .core_ready    (core_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected output beats: {lane, is_tag, last}.
  logic [9:0]   exp_q[$];

  // Reference model: each field is the accepted beats concatenated in order.
  logic [127:0] mfield [4];
  int           mcnt   [4];
  int           nbeats [4] = '{16, 16, 5, 13};

  localparam logic [Y-1:0] PLAN_DATA = 104'hC0C1C2C3C4C5C6C7C8C9CACBCC;
  localparam logic [127:0] PLAN_TAG  = 128'hD0D1D2D3D4D5D6D7D8D9DADBDCDDDEDF;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] exp_loaded();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (mcnt[i] == nbeats[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mfield[i] = '0;
      mcnt[i]   = 0;
    end
  endtask

  // End of an operation: key survives (KEEP_KEY=1), the rest clears.
  task automatic model_end_op();
    for (int i = 1; i < 4; i++) begin
      mfield[i] = '0;
      mcnt[i]   = 0;
    end
  endtask

  task automatic write_beat(input int sel, input logic [7:0] val);
    bit drop;
    drop = (mcnt[sel] >= nbeats[sel]);
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'(sel);
    bus.in_lane  = val;
    tick();
    bus.in_valid = 1'b0;
    if (!drop) begin
      mfield[sel] = (mfield[sel] << 8) | 128'(val);
      mcnt[sel]++;
    end
    check("err_after_write", err, drop);
    check("loaded_after_write", loaded, exp_loaded());
  endtask

  task automatic load_field(input int sel, input int n, input int base, input bit rnd);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
      write_beat(sel, v);
    end
  endtask

  task automatic check_fields(input string tag);
    check({tag, "_key"},   core_key,   mfield[0]);
    check({tag, "_nonce"}, core_nonce, mfield[1]);
    check({tag, "_ad"},    core_ad,    mfield[2][L-1:0]);
    check({tag, "_data"},  core_data,  mfield[3][Y-1:0]);
  endtask

  // mode 0: out_ready held 1; 1: toggles 0,1,0,1 from the first valid
  // cycle; 2: random. early: core_ready already high (with wrong data) while
  // start is accepted and while core_start is high.
  task automatic run_op(input bit dec, input int delay, input int mode, input bit early,
                        input logic [Y-1:0] d, input logic [127:0] t);
    int ucnt;
    bit ended;
    if (early) begin
      core_ready    = 1'b1;
      core_out_data = ~d;
      core_tag      = ~t;
    end
    start   = 1'b1;
    decrypt = dec;
    tick();
    start   = 1'b0;
    decrypt = ~dec;
    check("core_start_pulse", core_start, 1'b1);
    check("busy_run", busy, 1'b1);
    check("in_ready_run", bus.in_ready, 1'b0);
    check("err_good_start", err, 1'b0);
    check("core_decrypt", core_decrypt, dec);
    check("loaded_at_start", loaded, 4'hF);
    check_fields("start");
    // A start request in RUN is ignored without err.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("core_start_one_cycle", core_start, 1'b0);
    check("err_start_in_run", err, 1'b0);
    check("busy_run2", busy, 1'b1);
    if (!early) begin
      core_ready = 1'b0;
      repeat (delay) tick();
    end
    core_out_data = d;
    core_tag      = t;
    core_ready    = 1'b1;
    for (int i = 0; i < Y / 8; i++)
      exp_q.push_back({8'(d >> (8 * (Y / 8 - 1 - i))), 1'b0, 1'b0});
    for (int i = 0; i < 16; i++)
      exp_q.push_back({8'(t >> (8 * (15 - i))), 1'b1, (i == 15)});
    tick();
    core_ready = 1'b0;
    check("out_valid_rise", bus.out_valid, 1'b1);
    ucnt  = 0;
    ended = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (bus.out_valid) begin
        ucnt++;
        if (mode == 0)      bus.out_ready = 1'b1;
        else if (mode == 1) bus.out_ready = ((ucnt % 2) == 0);
        else                bus.out_ready = 1'($urandom_range(0, 1));
        tick();
      end else begin
        ended = 1'b1;
        break;
      end
    end
    bus.out_ready = 1'b0;
    if (!ended) begin
      total++;
      bad++;
      $display("FAIL unload_timeout: out_valid still high after %0d cycles", ucnt);
    end
    if (mode == 0) check("unload_cycles_ready", ucnt, 29);
    if (mode == 1) check("unload_cycles_toggle", ucnt, 58);
    model_end_op();
    check("in_ready_after_unload", bus.in_ready, 1'b1);
    check("busy_after_unload", busy, 1'b0);
    check("loaded_after_unload", loaded, exp_loaded());
    check("scoreboard_drained", exp_q.size(), 0);
    check_fields("after");
  endtask

  // Monitor: compares beats on handshakes and holds stalled beats stable.
  logic [9:0] mon_cur;
  logic [9:0] mon_exp;
  logic [9:0] stall_v;
  bit         stall_f = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        stall_f = 1'b0;
      end else begin
        mon_cur = {bus.out_lane, bus.out_is_tag, bus.out_last};
        if (stall_f && bus.out_valid) check("stall_hold", mon_cur, stall_v);
        stall_f = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected: got %0h with no beat expected", mon_cur);
          end else begin
            mon_exp = exp_q.pop_front();
            check("beat", mon_cur, mon_exp);
          end
        end else if (bus.out_valid) begin
          stall_f = 1'b1;
          stall_v = mon_cur;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [Y-1:0] rd;
    logic [127:0] rt;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_lane   = '0;
    bus.out_ready = 1'b0;
    model_reset();

    #3;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_loaded", loaded, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_core_start", core_start, 1'b0);
    check("rst_core_decrypt", core_decrypt, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_lane", bus.out_lane, 8'h00);
    check("rst_out_is_tag", bus.out_is_tag, 1'b0);
    check("rst_out_last", bus.out_last, 1'b0);
    check_fields("rst");
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Incomplete start: key and nonce only.
    load_field(0, 16, 8'h00, 1'b0);
    load_field(1, 16, 8'h10, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_incomplete_start", err, 1'b1);
    check("no_core_start_incomplete", core_start, 1'b0);
    check("in_ready_incomplete", bus.in_ready, 1'b1);
    check("loaded_incomplete", loaded, 4'b0011);
    tick();
    check("err_single_cycle", err, 1'b0);

    // Complete the load.
    load_field(2, 5, 8'hA0, 1'b0);
    load_field(3, 13, 8'hB0, 1'b0);
    check("loaded_full", loaded, 4'hF);
    check("plan_core_key", core_key, 128'h000102030405060708090A0B0C0D0E0F);
    check("plan_core_ad", core_ad, 40'hA0A1A2A3A4);

    // Overfill: sixth AD beat is dropped.
    write_beat(2, 8'hFF);
    check("overfill_ad_unchanged", core_ad, 40'hA0A1A2A3A4);

    // Unload with out_ready held high.
    run_op(1'b1, 18, 0, 1'b0, PLAN_DATA, PLAN_TAG);
    check("keep_key_loaded", loaded, 4'b0001);

    // Backpressure: same result, out_ready toggling.
    load_field(1, 16, 8'h10, 1'b0);
    load_field(2, 5, 8'hA0, 1'b0);
    load_field(3, 13, 8'hB0, 1'b0);
    run_op(1'b0, 5, 1, 1'b0, PLAN_DATA, PLAN_TAG);

    // Randomised operations, key retained; a key write is refused.
    for (int op = 0; op < 4; op++) begin
      write_beat(0, 8'($urandom_range(0, 255)));
      load_field(3, 13, 0, 1'b1);
      load_field(1, 16, 0, 1'b1);
      load_field(2, 5, 0, 1'b1);
      rd = 104'({$urandom(), $urandom(), $urandom(), $urandom()});
      rt = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op(1'($urandom_range(0, 1)), $urandom_range(0, 8), 2, (op % 2) == 0, rd, rt);
    end

    // Reset during RUN.
    load_field(1, 16, 0, 1'b1);
    load_field(2, 5, 0, 1'b1);
    load_field(3, 13, 0, 1'b1);
    start   = 1'b1;
    decrypt = 1'b1;
    tick();
    start   = 1'b0;
    decrypt = 1'b0;
    check("core_start_before_reset", core_start, 1'b1);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 1'b1);
    check("arst_loaded", loaded, 4'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_err", err, 1'b0);
    check("arst_core_start", core_start, 1'b0);
    check("arst_core_decrypt", core_decrypt, 1'b0);
    check("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out_lane", bus.out_lane, 8'h00);
    check("arst_core_key", core_key, 128'h0);
    model_reset();
    tick();
    rst = 1'b1;
    tick();
    check("loaded_after_release", loaded, 4'h0);

    // Fresh full load starts normally.
    load_field(0, 16, 0, 1'b1);
    load_field(1, 16, 0, 1'b1);
    load_field(2, 5, 0, 1'b1);
    load_field(3, 13, 0, 1'b1);
    rd = 104'({$urandom(), $urandom(), $urandom(), $urandom()});
    rt = {$urandom(), $urandom(), $urandom(), $urandom()};
    run_op(1'b1, 3, 2, 1'b0, rd, rt);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ascon_lane_io.md
# ascon_lane_io

- Parametrised serial front end for the Ascon AEAD core. Loads key, nonce, associated data and input data over a W-bit lane with a valid/ready handshake, then starts the core. Captures the core's output data and tag and streams them back out, MSB first, with backpressure.
- Sits between the chip-level pin/bus interface and the core. It replaces fixed 1-bit, all-fields-in-parallel shifting with per-field loading, explicit start checks, and optional key retention across operations.

## Interface
- K, 128, key width.
- L, 40, associated-data width.
- Y, 104, input/output data width.
- W, 8, lane width; legal values 1, 2, 4, 8. K, 128, L and Y must be multiples of W, otherwise elaboration fails.
- KEEP_KEY, 1, when 1 the key and its loaded flag survive the end of an operation.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  lane write request.
- in_ready  out  1  lane write accepted when both in_valid and in_ready are 1.
- in_sel  in  2  target field: 0 key, 1 nonce, 2 AD, 3 data.
- in_lane  in  W  write payload.
- start  in  1  request to start the core.
- decrypt  in  1  mode, sampled with an accepted start.
- loaded  out  4  per-field complete flags, bit index = in_sel.
- busy  out  1  high in RUN and UNLOAD.
- err  out  1  one-cycle protocol-error pulse.
- core_key / core_nonce / core_ad / core_data  out  K / 128 / L / Y  field registers driven to the core.
- core_start  out  1  one-cycle core start pulse.
- core_decrypt  out  1  latched mode.
- core_out_data  in  Y  core result.
- core_tag  in  128  core tag.
- core_ready  in  1  core done (level).
- out_valid  out  1  output beat valid.
- out_ready  in  1  output beat taken.
- out_lane  out  W  output payload.
- out_is_tag  out  1  current beat belongs to the tag.
- out_last  out  1  final beat of the operation.

## Operation
- FSM states: LOAD (reset state), RUN, UNLOAD.
- **LOAD:** in_ready=1.
  - An accepted write to a field that is not yet full shifts that field left by W and inserts in_lane at the LSBs.
  - Each field has its own beat counter; the field is full at N/W beats, where N is the field width. Its loaded bit is set when the final beat is accepted.
  - A write to a full field is dropped (field unchanged) and err pulses.
- **start in LOAD:**
  - If loaded==4'b1111, evaluated on the flags before any same-cycle write: latch decrypt into core_decrypt, pulse core_start on the next cycle, go to RUN.
  - Otherwise: err pulses, state stays LOAD, no core_start.
  - A same-cycle write is still accepted.
  - start in any state other than LOAD is ignored, with no err.
- **RUN:** in_ready=0, busy=1.
  - core_ready is ignored in the cycle core_start is high.
  - From the following cycle, core_ready=1 captures core_out_data into the data shift register and core_tag into the tag shift register, then the FSM goes to UNLOAD.
- **UNLOAD:** out_valid=1.
  - Beats are Y/W data beats, MSB first (out_is_tag=0), then 128/W tag beats, MSB first (out_is_tag=1).
  - The shift register advances only on out_valid && out_ready.
  - out_last=1 during the final beat.
  - The final handshake returns the FSM to LOAD. On that transition, nonce, AD, data, their counters and loaded bits clear. Key, its counter and loaded[0] also clear unless KEEP_KEY=1.
- At most one err pulse per cycle.

## Timing
- Reset (rst=0, asynchronous): state LOAD, all field registers 0, counters 0.
- Output values during reset: in_ready=1, loaded=0, busy=0, err=0, core_start=0, core_decrypt=0, out_valid=0, out_lane=0, out_is_tag=0, out_last=0.
- Reset mid-operation in any state aborts immediately to these values; no partial output is resumed.
- Load latency: a field is complete N/W accepted beats after its first write. loaded updates the cycle after the final beat.
- core_start is high exactly one cycle, the cycle after start is accepted. core_* field outputs are stable from the start-accept cycle through the end of UNLOAD.
- out_valid rises the cycle after core_ready is sampled. The first beat is core_out_data[Y-1:Y-W].
- While out_valid && !out_ready, out_lane, out_is_tag and out_last hold stable.
- Minimum UNLOAD length is (Y+128)/W cycles: 29 at defaults.
- in_ready returns to 1 the cycle after the last output handshake.

## Test plan
- **Full load and start:** key beats 0x00..0x0F, nonce 0x10..0x1F, AD 0xA0..0xA4, data 0xB0..0xBC, then start with decrypt=1.
  - Expect loaded=4'hF and core_key=128'h000102..0F.
  - Expect core_ad=40'hA0A1A2A3A4, core_start high for one cycle only, core_decrypt=1, busy=1.
- **Incomplete start:** load key and nonce only, then start.
  - Expect err for 1 cycle, no core_start, in_ready stays 1, loaded=4'b0011.
- **Overfill:** a 6th AD beat 0xFF.
  - Expect err pulse, core_ad unchanged at 40'hA0A1A2A3A4.
- **Unload with out_ready held 1:** core_ready 20 cycles after core_start, core_out_data=104'hC0C1..CC, core_tag=128'hD0..DF.
  - Expect 29 beats: 0xC0..0xCC with out_is_tag=0, then 0xD0..0xDF with out_is_tag=1, out_last on beat 29.
  - Afterwards loaded=4'b0001 (KEEP_KEY=1).
- **Backpressure:** toggle out_ready every cycle during UNLOAD.
  - Expect the beat sequence to match the previous scenario and out_lane stable while stalled. Total duration is 58 cycles.
- **Reset in RUN:** drop rst two cycles after core_start.
  - Expect all outputs at their reset values asynchronously and loaded=0 after release.
  - A fresh full load then starts normally.
